// File: rtl/cpu_reg_wb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_reg_wb_ctrl_pkg
// Brief    : Shared CPU types for the register-file writeback path.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_reg_wb_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } starve_state_e;

    // x0 is never tracked; the reduced file only covers x1..x15.
    function automatic logic reg_tracked(input logic [REG_ADDR_W-1:0] rd,
                                         input logic                  more_regs);
        return (rd != '0) && (more_regs || !rd[REG_ADDR_W-1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : cpu_reg_scoreboard
// Brief    : Busy bits for registers with an outstanding load.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_reg_scoreboard
    import cpu_reg_wb_ctrl_pkg::*;
#(
    parameter logic MORE_REGISTERS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  busy_rs1,
    output logic                  busy_rs2,
    output logic                  busy_rd
);

    localparam int NUM_REGS = MORE_REGISTERS ? 32 : 16;
    localparam int IDX_W    = MORE_REGISTERS ? 5 : 4;

    logic [NUM_REGS-1:0] r_busy;

    function automatic logic lookup(input logic [REG_ADDR_W-1:0] addr,
                                    input logic [NUM_REGS-1:0]   vec);
        return reg_tracked(addr, MORE_REGISTERS) && vec[addr[IDX_W-1:0]];
    endfunction

    // Set takes precedence over clear when both target the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (set_en && (set_rd == REG_ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (clr_en && (clr_rd == REG_ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_rs1 = lookup(rs1, r_busy);
    assign busy_rs2 = lookup(rs2, r_busy);
    assign busy_rd  = lookup(rd,  r_busy);

endmodule
`default_nettype wire

// File: rtl/cpu_reg_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_reg_wb_ctrl
// Brief    : ALU/load writeback arbiter with load scoreboard and starvation hold.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_reg_wb_ctrl
    import cpu_reg_wb_ctrl_pkg::*;
#(
    parameter logic MORE_REGISTERS = 1'b1,
    parameter int   STARVE_LIMIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_wr,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic                  ld_issue,
    input  logic [REG_ADDR_W-1:0] ld_issue_rd,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    output logic                  hazard,
    output logic                  alu_hold,
    output logic                  wr,
    output logic [REG_ADDR_W-1:0] addr_wr,
    output logic [XLEN-1:0]       data_wr,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]       fwd_data
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic                  w_ld_drop, w_ld_accept, w_ld_blocked;
    wb_src_e               w_src;
    logic                  w_wr_nxt;
    logic [REG_ADDR_W-1:0] w_addr_nxt;
    logic [XLEN-1:0]       w_data_nxt;

    wb_src_e               r_src;
    logic                  r_wr;
    logic [REG_ADDR_W-1:0] r_addr_wr;
    logic [XLEN-1:0]       r_data_wr;

    starve_state_e         r_state, w_state_nxt;
    logic [3:0]            r_starve_cnt, w_cnt_nxt;
    logic                  r_alu_hold;

    logic                  w_busy_rs1, w_busy_rs2, w_busy_rd;
    logic                  w_issue_hit;

    // A load that would be dropped anyway never has to wait for the ALU.
    assign w_ld_drop    = !reg_tracked(ld_rd, MORE_REGISTERS);
    assign ld_ready     = !alu_wr || w_ld_drop;
    assign w_ld_accept  = ld_valid && ld_ready;
    assign w_ld_blocked = ld_valid && !ld_ready;

    always_comb begin
        w_src      = WB_NONE;
        w_wr_nxt   = 1'b0;
        w_addr_nxt = '0;
        w_data_nxt = '0;
        if (alu_wr) begin
            w_src      = WB_ALU;
            w_wr_nxt   = reg_tracked(alu_rd, MORE_REGISTERS);
            w_addr_nxt = alu_rd;
            w_data_nxt = alu_data;
        end else if (ld_valid) begin
            w_src      = WB_LOAD;
            w_wr_nxt   = !w_ld_drop;
            w_addr_nxt = ld_rd;
            w_data_nxt = ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src     <= WB_NONE;
            r_wr      <= 1'b0;
            r_addr_wr <= '0;
            r_data_wr <= '0;
        end else begin
            r_src     <= w_src;
            r_wr      <= w_wr_nxt;
            r_addr_wr <= w_addr_nxt;
            r_data_wr <= w_data_nxt;
        end
    end

    cpu_reg_scoreboard #(
        .MORE_REGISTERS (MORE_REGISTERS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (ld_issue && reg_tracked(ld_issue_rd, MORE_REGISTERS)),
        .set_rd   (ld_issue_rd),
        .clr_en   (r_wr && (r_src == WB_LOAD)),
        .clr_rd   (r_addr_wr),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .busy_rs1 (w_busy_rs1),
        .busy_rs2 (w_busy_rs2),
        .busy_rd  (w_busy_rd)
    );

    assign w_issue_hit = ld_issue && (ld_issue_rd != '0) &&
                         ((ld_issue_rd == dec_rs1) || (ld_issue_rd == dec_rs2) ||
                          (ld_issue_rd == dec_rd));
    assign hazard = w_busy_rs1 || w_busy_rs2 || w_busy_rd || w_issue_hit;

    always_comb begin
        w_cnt_nxt   = r_starve_cnt;
        w_state_nxt = r_state;
        if (w_ld_accept) begin
            w_cnt_nxt = 4'd0;
        end else if (w_ld_blocked && (r_starve_cnt != 4'hF)) begin
            w_cnt_nxt = r_starve_cnt + 4'd1;
        end
        case (r_state)
            ST_IDLE: if (w_ld_blocked)
                         w_state_nxt = (w_cnt_nxt >= C_STARVE_LIMIT) ? ST_HOLD : ST_WAIT;
            ST_WAIT: if (w_ld_accept)                        w_state_nxt = ST_IDLE;
                     else if (w_cnt_nxt >= C_STARVE_LIMIT)  w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_ld_accept)                        w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_starve_cnt <= 4'd0;
            r_alu_hold   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_cnt_nxt;
            r_alu_hold   <= (w_state_nxt == ST_HOLD);
        end
    end

    assign alu_hold  = r_alu_hold;
    assign wr        = r_wr;
    assign addr_wr   = r_addr_wr;
    assign data_wr   = r_data_wr;
    assign fwd_valid = r_wr;
    assign fwd_rd    = r_addr_wr;
    assign fwd_data  = r_data_wr;

endmodule
`default_nettype wire

// File: doc/cpu_reg_wb_ctrl.md
# cpu_reg_wb_ctrl

Writeback controller for the CPU register file. It arbitrates the ALU writeback and the load-unit writeback onto the register file's single write port, and keeps a busy-bit scoreboard of registers with outstanding loads. It drives decode's hazard line and a one-entry forwarding tap. It sits between execute/memory and `cpu_reg_file`, driving that block's `wr`/`addr_wr`/`data_wr`.

## Interface
- `MORE_REGISTERS`, 1'b1, 1: x1..x31 are tracked; 0: x1..x15 only.
- `STARVE_LIMIT`, 4, consecutive blocked load cycles before `alu_hold` asserts (range 1..15).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_wr` / `alu_rd` / `alu_data`  in  1/5/32  ALU writeback request; cannot be back-pressured.
- `ld_valid` / `ld_rd` / `ld_data`  in  1/5/32  load writeback request; held stable until accepted.
- `ld_ready`  out  1  load accepted this cycle when `ld_valid && ld_ready`.
- `ld_issue` / `ld_issue_rd`  in  1/5  a load to `ld_issue_rd` enters memory stage; marks it busy.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  decode-stage operand and destination addresses.
- `hazard`  out  1  decode must stall (combinational).
- `alu_hold`  out  1  registered; the pipeline must not present `alu_wr` while high.
- `wr` / `addr_wr` / `data_wr`  out  1/5/32  registered write port to the register file.
- `fwd_valid` / `fwd_rd` / `fwd_data`  out  1/5/32  bypass tap, equal to `wr`/`addr_wr`/`data_wr`.

## Operation
- **Arbitration, every cycle:** the ALU has priority. `ld_ready = !alu_wr || ` (write dropped per the next rule).
  - Winner is `alu_wr` if asserted, else the accepted load, else none.
- **Dropped writes:** a write to x0 is dropped. With `MORE_REGISTERS=0`, a write with `rd[4]=1` is also dropped.
  - A dropped write still counts as accepted.
  - It produces `wr=0`.
  - A dropped load still clears nothing.
- **Output register:** the winner is latched into `wr`/`addr_wr`/`data_wr` at the edge. The register file commits it at the following edge.
- **Scoreboard:** one busy bit per tracked register, x0 never busy.
  - Set at the edge where `ld_issue` is high, if `ld_issue_rd` is tracked and nonzero.
  - Cleared at the edge where `wr` is high, the output holds a load write, and `addr_wr` matches.
  - If set and clear hit the same register at the same edge, set wins.
- **Hazard:** `hazard` is asserted when any of the following holds:
  - `busy[dec_rs1]`, `busy[dec_rs2]` or `busy[dec_rd]` is set (x0 reads as 0);
  - `ld_issue` is high and `ld_issue_rd` is nonzero and equals any of `dec_rs1`/`dec_rs2`/`dec_rd`.
- **ALU write to a busy register:** this cannot happen if `hazard` is honoured. If it does, the write proceeds and the busy bit is unchanged.
- **Starvation counter:** a 4-bit counter increments each cycle `ld_valid && !ld_ready`, saturating at 15.
  - It resets to 0 on load acceptance.
  - `alu_hold` sets at the edge where the counter reaches `STARVE_LIMIT`.
  - `alu_hold` clears at the edge after the load is accepted.
  - If `alu_wr` is asserted during hold, the ALU still wins.
- **States:** IDLE (no pending load), WAIT (load blocked, counting), HOLD (`alu_hold` high).
  - IDLE→WAIT on a blocked load.
  - WAIT→HOLD at the limit.
  - WAIT/HOLD→IDLE on acceptance.

## Timing
- **Reset values:** `wr=0`, `addr_wr=0`, `data_wr=0`, `fwd_*=0`, `alu_hold=0`, counter 0, state IDLE, all busy bits 0.
  - `ld_ready` and `hazard` are combinational, so after reset `ld_ready = !alu_wr`.
- **Latency:** request to `wr` high is 1 cycle; request to register file updated is 2 edges.
- **Busy clear:** a busy bit clears at the same edge the register file commits the load. `hazard` drops the cycle after that.
- **Mid-operation reset:** the scoreboard and hold are cleared, and any in-flight write in the output register is lost. Upstream units are reset together.

## Structure
- The shared CPU package holds:
  - `XLEN=32` and `REG_ADDR_W=5`;
  - the writeback source enum {NONE, ALU, LOAD};
  - the starvation state enum {IDLE, WAIT, HOLD}.
- Sub-module `cpu_reg_scoreboard` holds the busy vector with set/clear ports and three lookup ports, sized by `MORE_REGISTERS`.

## Test plan
- ALU writes x5=0x1234 with no load present → `wr=1`, `addr_wr=5`, `data_wr=0x1234` one cycle later; `ld_ready=1`.
- `ld_issue` for x7, then `dec_rs1=7` → `hazard=1` until the edge the load write to x7 commits; `hazard=0` the next cycle.
- `alu_wr` and `ld_valid` in the same cycle → ALU data written, `ld_ready=0`; the load is written the next cycle after `alu_wr` drops.
- `alu_wr` held high for 6 cycles with a load waiting and `STARVE_LIMIT=4` → `alu_hold=1` after 4 blocked cycles; the load is accepted once `alu_wr` drops; `alu_hold=0` the following cycle.
- Write to x0 with `MORE_REGISTERS=0`, and a write to x20 → `wr` stays 0 for both; `ld_issue_rd=0` sets no busy bit.
- `rst` pulsed while x3 is busy and `alu_hold=1` → all outputs and busy bits return to 0 immediately and asynchronously.
